dma_write_stream: RTL and testbench

- Upstream client stage for the AXI write adapter.
- Accepts a write descriptor (base address, beat count, beat size) and a stream of data words.
- Splits the descriptor into INCR requests that never exceed AXI_MAX_BURST_LEN beats and never cross a 4KB boundary, so the adapter issues exactly one AXI burst (and one core_write_resp_ok) per request.
- Drives the adapter's core_write_* interface. Pulses done once all responses for the descriptor have returned.

---
 rtl/dma_write_stream_pkg.sv | 20 ++
 rtl/dma_write_stream_fifo.sv | 71 +++++++
 rtl/dma_write_stream.sv | 175 +++++++++++++++++
 tb/tb_dma_write_stream.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_write_stream_pkg.sv
// Shared definitions for the DMA write stream client.
//   - state_e        : controller FSM states
//   - AXI_BURST_INCR : AXI burst-type encoding for incrementing bursts
//   - ADDR_4KB / LOG_4KB : the AXI 4KB page that no burst may cross
package dma_write_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_REQ,
    ST_DATA,
    ST_WAIT_RESP,
    ST_FIN
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         ADDR_4KB       = 4096;
  localparam int         LOG_4KB        = 12;

endpackage

// File: rtl/dma_write_stream_fifo.sv
// Synchronous FIFO used as the write-data buffer.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset (flushes contents)
//   push_valid/ready/data: write side; push_ready is "not full"
//   pop_valid/ready/data : read side; pop_data is the combinational head word
// A pushed word becomes visible at the head one cycle after the push.
// When full, a push is refused even if a pop happens in the same cycle.
module dma_write_stream_fifo #(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int DEPTH = 1 << LOGDEPTH;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOGDEPTH:0]   count_q, count_d;
  logic                push, pop;

  assign push_ready = (count_q != (LOGDEPTH + 1)'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_ready && pop_valid;
  assign pop_data   = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // paths that skip an assignment infer latches.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count is
  // enough to flush it, and a resettable array costs a reset net per bit.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dma_write_stream.sv
// Upstream client of the AXI write adapter.
// Accepts a descriptor (desc_*) and a data stream (s_*), splits the descriptor
// into INCR requests of at most AXI_MAX_BURST_LEN beats that never cross a 4KB
// page, and drives the adapter's core_write_* interface. done pulses once all
// burst responses (core_write_resp_ok) for the descriptor have returned.
// Ports:
//   desc_valid/ready, desc_addr/len/size : descriptor handshake
//   s_data/valid/ready                   : data stream into the internal buffer
//   core_write_request_*, addr/len/size/burst : per-burst request to adapter
//   core_write_data/valid/ready          : data beats to adapter
//   core_write_resp_ok                   : one pulse per completed burst
//   busy, done                           : status
module dma_write_stream
  import dma_write_stream_pkg::*;
#(
  parameter int AXI_AWIDTH        = 64,
  parameter int AXI_DWIDTH        = 64,
  parameter int AXI_MAX_BURST_LEN = 256,
  parameter int FIFO_LOGDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [AXI_AWIDTH-1:0] desc_addr,
  input  logic [31:0]           desc_len,
  input  logic [2:0]            desc_size,
  input  logic [AXI_DWIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  core_write_request_valid,
  input  logic                  core_write_request_ready,
  output logic [AXI_AWIDTH-1:0] core_write_addr,
  output logic [31:0]           core_write_len,
  output logic [2:0]            core_write_size,
  output logic [1:0]            core_write_burst,
  output logic [AXI_DWIDTH-1:0] core_write_data,
  output logic                  core_write_data_valid,
  input  logic                  core_write_data_ready,
  input  logic                  core_write_resp_ok,
  output logic                  busy,
  output logic                  done
);

  localparam logic [8:0] MAX_BURST = 9'(AXI_MAX_BURST_LEN);

  state_e                state_q, state_d;
  logic [AXI_AWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [31:0]           remaining_q, remaining_d;
  logic [2:0]            size_q, size_d;
  logic [8:0]            chunk_q, chunk_d;      // 9 bits so 256 fits
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic [7:0]            outstanding_q, outstanding_d;

  logic [12:0] room_4k, beats_to_4k;
  logic [8:0]  chunk_calc;
  logic        fifo_valid, fifo_pop, req_fire;

  dma_write_stream_fifo #(
    .WIDTH   (AXI_DWIDTH),
    .LOGDEPTH(FIFO_LOGDEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_valid(s_valid),
    .push_ready(s_ready),
    .push_data (s_data),
    .pop_valid (fifo_valid),
    .pop_ready (fifo_pop),
    .pop_data  (core_write_data)
  );

  // Beats left in the current 4KB page; room_4k ranges 1..4096, hence 13 bits.
  assign room_4k     = 13'(ADDR_4KB) - {1'b0, cur_addr_q[LOG_4KB-1:0]};
  assign beats_to_4k = room_4k >> size_q;

  always_comb begin
    chunk_calc = MAX_BURST;
    if (remaining_q < 32'(chunk_calc)) chunk_calc = remaining_q[8:0];
    if (beats_to_4k < 13'(chunk_calc)) chunk_calc = beats_to_4k[8:0];
  end

  assign req_fire         = (state_q == ST_REQ) && core_write_request_ready;
  assign core_write_addr  = cur_addr_q;
  assign core_write_len   = {23'd0, chunk_q - 9'd1};
  assign core_write_size  = size_q;
  assign core_write_burst = AXI_BURST_INCR;
  assign busy             = (state_q != ST_IDLE);

  always_comb begin
    state_d                  = state_q;
    cur_addr_d               = cur_addr_q;
    remaining_d              = remaining_q;
    size_d                   = size_q;
    chunk_d                  = chunk_q;
    beat_cnt_d               = beat_cnt_q;
    desc_ready               = 1'b0;
    core_write_request_valid = 1'b0;
    core_write_data_valid    = 1'b0;
    fifo_pop                 = 1'b0;
    done                     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          cur_addr_d  = desc_addr;
          remaining_d = desc_len;
          size_d      = desc_size;
          state_d     = (desc_len == '0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        chunk_d = chunk_calc;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        core_write_request_valid = 1'b1;
        if (core_write_request_ready) begin
          cur_addr_d  = cur_addr_q + (AXI_AWIDTH'(chunk_q) << size_q);
          remaining_d = remaining_q - 32'(chunk_q);
          beat_cnt_d  = '0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        core_write_data_valid = fifo_valid;
        fifo_pop              = fifo_valid && core_write_data_ready;
        if (fifo_pop) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (beat_cnt_q == chunk_q - 9'd1)
            state_d = (remaining_q != '0) ? ST_CALC : ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (outstanding_q == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Coincident request and response cancel; a response with nothing
  // outstanding is dropped rather than wrapping the counter.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !core_write_resp_ok)
      outstanding_d = outstanding_q + 8'd1;
    else if (!req_fire && core_write_resp_ok && outstanding_q != '0)
      outstanding_d = outstanding_q - 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      size_q        <= '0;
      chunk_q       <= '0;
      beat_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      size_q        <= size_d;
      chunk_q       <= chunk_d;
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_dma_write_stream.sv
// Self-checking bench for dma_write_stream. The bench plays the stream source
// and the AXI write adapter; expected requests come from a page/burst split
// computed with plain arithmetic, expected data from the order of accepted
// stream words.
module tb_dma_write_stream;

  logic        clk = 1'b0;
  logic        resetn;
  logic        desc_valid, desc_ready;
  logic [63:0] desc_addr;
  logic [31:0] desc_len;
  logic [2:0]  desc_size;
  logic [63:0] s_data;
  logic        s_valid, s_ready;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [31:0] req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [63:0] wr_data;
  logic        data_valid, data_ready;
  logic        resp_ok, busy, done;

  always #5 clk = ~clk;

  dma_write_stream dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .desc_valid              (desc_valid),
    .desc_ready              (desc_ready),
    .desc_addr               (desc_addr),
    .desc_len                (desc_len),
    .desc_size               (desc_size),
    .s_data                  (s_data),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .core_write_request_valid(req_valid),
    .core_write_request_ready(req_ready),
    .core_write_addr         (req_addr),
    .core_write_len          (req_len),
    .core_write_size         (req_size),
    .core_write_burst        (req_burst),
    .core_write_data         (wr_data),
    .core_write_data_valid   (data_valid),
    .core_write_data_ready   (data_ready),
    .core_write_resp_ok      (resp_ok),
    .busy                    (busy),
    .done                    (done)
  );

  typedef struct {
    longint unsigned addr;
    int unsigned     len_m1;
  } req_t;

  req_t            exp_req[$];
  req_t            got_req;
  logic [63:0]     pending[$];    // words not yet accepted by the DUT
  logic [63:0]     exp_data[$];   // accepted words, in order
  int unsigned     open_beats[$]; // beats still owed per issued burst
  int unsigned     exp_size;
  int              resp_pending = 0, resp_timer = 0;
  int              cyc = 0, n_cmp = 0, n_err = 0;
  int              done_cnt = 0, done_cyc = 0, last_resp_cyc = 0, beats_seen = 0;
  bit              stream_en = 0, stall = 0, force_resp = 0, dr_toggle = 0;
  bit              prev_hold = 0;
  logic [63:0]     prev_addr;
  logic [31:0]     prev_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Input drivers: update 1ns after the rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!resetn) begin
      s_valid    = 1'b0;
      req_ready  = 1'b0;
      data_ready = 1'b0;
      resp_ok    = 1'b0;
    end else begin
      s_valid    = stream_en && !stall && (pending.size() > 0);
      s_data     = (pending.size() > 0) ? pending[0] : '0;
      req_ready  = ($urandom_range(0, 3) != 0);
      data_ready = dr_toggle ? ~data_ready : ($urandom_range(0, 3) != 0);
      resp_ok    = force_resp;
      if (resp_timer > 0) resp_timer--;
      else if (resp_pending > 0) begin
        resp_ok      = 1'b1;
        resp_pending--;
        resp_timer   = $urandom_range(0, 4);
      end
    end
  end

  // Adapter model and scoreboard: handshakes observed on the falling edge
  // complete on the following rising edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (s_valid && s_ready) exp_data.push_back(pending.pop_front());
      if (prev_hold) begin
        check("req_hold_valid", 64'(req_valid), 64'(1));
        check("req_hold_addr", req_addr, prev_addr);
        check("req_hold_len", 64'(req_len), 64'(prev_len));
      end
      prev_hold = req_valid && !req_ready;
      prev_addr = req_addr;
      prev_len  = req_len;
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) check("extra_request", 64'(exp_req.size()), 64'(1));
        else begin
          got_req = exp_req.pop_front();
          check("req_addr", req_addr, got_req.addr);
          check("req_len", 64'(req_len), 64'(got_req.len_m1));
          check("req_size", 64'(req_size), 64'(exp_size));
          check("req_burst", 64'(req_burst), 64'(2'b01));
          open_beats.push_back(got_req.len_m1 + 1);
        end
      end
      if (data_valid && data_ready) begin
        beats_seen++;
        if (open_beats.size() == 0) check("beat_outside_burst", 64'(open_beats.size()), 64'(1));
        else if (exp_data.size() == 0) check("beat_without_data", 64'(exp_data.size()), 64'(1));
        else begin
          check("data", wr_data, exp_data.pop_front());
          open_beats[0]--;
          if (open_beats[0] == 0) begin
            void'(open_beats.pop_front());
            resp_pending++;
          end
        end
      end
      if (resp_ok) last_resp_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Expected split: each request is bounded by what remains, the maximum
  // burst length and the room left in the current 4KB page.
  task automatic start_desc(input longint unsigned addr, input int unsigned len,
                            input int unsigned size, input bit feed, output int d_cyc);
    longint unsigned a, rem, b, c;
    check("desc_aligned", addr & ((64'd1 << size) - 64'd1), 64'd0);
    check("desc_size_ok", 64'(size <= 3), 64'd1);
    a   = addr;
    rem = len;
    while (rem > 0) begin
      b = (64'd4096 - (a % 64'd4096)) >> size;
      c = rem;
      if (c > 256) c = 256;
      if (c > b) c = b;
      exp_req.push_back('{a, 32'(c - 1)});
      a   = a + (c << size);
      rem = rem - c;
    end
    exp_size = size;
    if (feed) repeat (len) pending.push_back({$urandom, $urandom});
    @(posedge clk); #1;
    desc_valid = 1'b1;
    desc_addr  = addr;
    desc_len   = len;
    desc_size  = 3'(size);
    @(negedge clk);
    check("desc_ready_idle", 64'(desc_ready), 64'd1);
    d_cyc = cyc;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(negedge clk); #1;
    check("desc_ready_drop", 64'(desc_ready), 64'd0);
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic finish_desc(input int unsigned len, input int d_cyc, input int start_done);
    int budget = 40 * len + 300;
    for (int i = 0; i < budget && done_cnt == start_done; i++) begin
      @(negedge clk); #1;
    end
    check("done_pulses", 64'(done_cnt - start_done), 64'd1);
    if (len == 0) check("done_cycle_len0", 64'(done_cyc), 64'(d_cyc + 1));
    else          check("done_cycle_after_resp", 64'(done_cyc), 64'(last_resp_cyc + 2));
    check("all_requests_seen", 64'(exp_req.size()), 64'd0);
    check("all_beats_seen", 64'(open_beats.size()), 64'd0);
    @(negedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_desc(input longint unsigned addr, input int unsigned len,
                          input int unsigned size, input bit feed);
    int d, s;
    s = done_cnt;
    start_desc(addr, len, size, feed, d);
    finish_desc(len, d, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_ready"}, 64'(desc_ready), 64'd1);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    check({tag, "_data_valid"}, 64'(data_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int d, s, b0;
    resetn     = 1'b0;
    desc_valid = 1'b0;
    desc_addr  = '0;
    desc_len   = '0;
    desc_size  = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    resp_ok    = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    resetn    = 1'b1;
    stream_en = 1'b1;

    // Pre-filled stream, single aligned burst.
    repeat (16) pending.push_back({$urandom, $urandom});
    repeat (20) @(negedge clk);
    run_desc(64'h1000, 16, 3, 0);

    // Long descriptor split on the maximum burst length.
    run_desc(64'h0, 600, 3, 1);

    // Split at a 4KB boundary.
    run_desc(64'h0FF0, 8, 3, 1);

    // Zero-length descriptor: no request at all.
    run_desc(64'h2000, 0, 3, 1);

    // A stray response while idle must not disturb the next descriptor.
    @(negedge clk); force_resp = 1'b1;
    @(negedge clk); force_resp = 1'b0;
    repeat (2) @(negedge clk);
    run_desc(64'h3000, 20, 2, 1);

    // Stream stall mid-burst.
    s = done_cnt;
    b0 = beats_seen;
    start_desc(64'h4000, 64, 3, 1, d);
    for (int i = 0; i < 2000 && beats_seen < b0 + 10; i++) @(negedge clk);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    finish_desc(64, d, s);

    // Adapter data_ready toggling every cycle.
    dr_toggle = 1'b1;
    run_desc(64'h5010, 40, 3, 1);
    dr_toggle = 1'b0;

    // Leftover beats stay buffered for the following descriptor.
    repeat (20) pending.push_back({$urandom, $urandom});
    run_desc(64'h6000, 16, 3, 0);
    run_desc(64'h7000, 4, 3, 0);

    // Address wrap past the top of the address space.
    run_desc(64'hFFFF_FFFF_FFFF_FFC0, 16, 3, 1);

    // Randomised descriptors near page boundaries, all sizes.
    for (int n = 0; n < 8; n++) begin
      int unsigned sz, ln;
      longint unsigned ad;
      sz = $urandom_range(0, 3);
      ln = $urandom_range(0, 300);
      ad = (64'($urandom_range(1, 15)) << 12) - (64'($urandom_range(0, 40)) << sz);
      run_desc(ad, ln, sz, 1);
    end

    // Asynchronous reset in the middle of a long descriptor.
    s = done_cnt;
    b0 = beats_seen;
    start_desc(64'h0, 600, 3, 1, d);
    for (int i = 0; i < 3000 && beats_seen < b0 + 50; i++) @(negedge clk);
    check("beats_before_reset", 64'(beats_seen >= b0 + 50), 64'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    pending.delete();
    exp_data.delete();
    exp_req.delete();
    open_beats.delete();
    resp_pending = 0;
    resp_timer   = 0;
    prev_hold    = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset_hold");
    check("no_done_on_abort", 64'(done_cnt), 64'(s));
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_desc(64'h8000, 32, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
